pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_sequencer_pkg.sv | 21 ++
 rtl/pll_reset_sequencer_if.sv | 23 ++
 rtl/pll_reset_sequencer_sync_2ff.sv | 22 ++
 rtl/pll_reset_sequencer.sv | 114 +++++++++++
 tb/tb_pll_reset_sequencer.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared state encoding for the PLL reset sequencer; board tops and ILA decode reuse it.
// Also provides the helper used to size the sequencer's cycle counter.
package pll_reset_sequencer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL-facing and system-facing signals of the reset sequencer.
// The master side is the sequencer; the slave side is the board/PLL/downstream logic.
interface pll_reset_sequencer_if;
    import pll_reset_sequencer_pkg::*;

    logic               pll_locked;
    logic               pll_rst;
    logic               sys_rst;
    logic               ready;
    logic               fail;
    logic [7:0]         relock_count;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  pll_locked,
        output pll_rst, sys_rst, ready, fail, relock_count, state_o
    );

    modport slave (
        output pll_locked,
        input  pll_rst, sys_rst, ready, fail, relock_count, state_o
    );
endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Single-bit synchronizer, STAGES flops deep; output lags the input by STAGES edges.
// Only a synchronous clear touches the data path.
module sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, waits for a stable lock, then releases sys_rst; retries on lock
// timeout and parks in a sticky FAIL after too many consecutive timeouts.
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES        = 2,
    parameter int MAX_RETRIES        = 3
) (
    input  logic                  clk_in1,
    input  logic                  reset,
    pll_reset_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES)) + 1;

    logic             lock_s;
    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d, retry_inc;
    logic [7:0]       relock_q, relock_d;
    logic             pll_rst_q, sys_rst_q, ready_q, fail_q;

    sync_2ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk_i (clk_in1),
        .clr_i (reset),
        .d_i   (bus.pll_locked),
        .q_o   (lock_s)
    );

    assign retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        retry_d  = retry_q;
        relock_d = relock_q;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock takes priority over a timeout landing on the same cycle.
                if (lock_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_inc;
                    cnt_d   = '0;
                    if ((MAX_RETRIES != 0) && (retry_inc == 8'(MAX_RETRIES))) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_PLL_RST;
                    end
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d  = ST_PLL_RST;
                    relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_FAIL;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they change on the same edge as the state register.
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            state_q   <= ST_PLL_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            relock_q  <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            relock_q  <= relock_d;
            pll_rst_q <= (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
            sys_rst_q <= (state_d != ST_RUN);
            ready_q   <= (state_d == ST_RUN);
            fail_q    <= (state_d == ST_FAIL);
        end
    end

    assign bus.pll_rst      = pll_rst_q;
    assign bus.sys_rst      = sys_rst_q;
    assign bus.ready        = ready_q;
    assign bus.fail         = fail_q;
    assign bus.relock_count = relock_q;
    assign bus.state_o      = state_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer with PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE_CYCLES=8.
// Each vector holds inputs for N cycles; the expected outputs after those cycles go through a queue.
module tb_pll_reset_sequencer;

    localparam logic [2:0] S_PRST = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_STAB = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_FAIL = 3'd4;

    typedef struct {
        logic       rst;
        logic       lock;
        int         n;
        logic [2:0] st;
        logic       pr;
        logic       sr;
        logic       rdy;
        logic       fl;
        logic [7:0] rc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;
    vec_t vecs[$];
    vec_t sb[$];

    pll_reset_sequencer_if bus();

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (4),
        .LOCK_TIMEOUT       (32),
        .LOCK_STABLE_CYCLES (8),
        .SYNC_STAGES        (2),
        .MAX_RETRIES        (3)
    ) dut (
        .clk_in1 (clk),
        .reset   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic l, input int n, input logic [2:0] st,
                                input logic pr, input logic sr, input logic rdy, input logic fl,
                                input logic [7:0] rc);
        vec_t v;
        v.rst = r; v.lock = l; v.n = n; v.st = st;
        v.pr = pr; v.sr = sr; v.rdy = rdy; v.fl = fl; v.rc = rc;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s (vector %0d): got %0h, expected %0h", name, idx, act, exp);
    endtask

    // Called at a negedge: drive, let n rising edges pass, then compare at the next negedge.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        rst = v.rst;
        bus.pll_locked = v.lock;
        sb.push_back(v);
        repeat (v.n) @(posedge clk);
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty (vector %0d): got 0 entries, expected 1", idx);
        end else begin
            passed++;
            e = sb.pop_front();
            chk("state",        idx, 8'(bus.state_o), 8'(e.st));
            chk("pll_rst",      idx, 8'(bus.pll_rst), 8'(e.pr));
            chk("sys_rst",      idx, 8'(bus.sys_rst), 8'(e.sr));
            chk("ready",        idx, 8'(bus.ready),   8'(e.rdy));
            chk("fail",         idx, 8'(bus.fail),    8'(e.fl));
            chk("relock_count", idx, bus.relock_count, e.rc);
        end
    endtask

    initial begin
        logic [7:0] rc;
        bus.pll_locked = 1'b0;

        // Normal bring-up: pll_rst is 4 cycles; sys_rst falls 2 sync + 1 detect + 8 stable edges after lock.
        vecs.push_back(mk(1, 0,  3, S_PRST, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0,  3, S_PRST, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0,  1, S_WAIT, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0,  6, S_WAIT, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 10, S_STAB, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1,  1, S_RUN,  0, 0, 1, 0, 0));
        // One-cycle lock drop in RUN, seen after synchronizer delay.
        vecs.push_back(mk(0, 0,  1, S_RUN,  0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1,  1, S_RUN,  0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1,  1, S_PRST, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1,  3, S_PRST, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1,  1, S_WAIT, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1,  1, S_STAB, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1,  7, S_STAB, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1,  1, S_RUN,  0, 0, 1, 0, 1));
        // Reset in RUN clears everything on the next edge.
        vecs.push_back(mk(1, 1,  1, S_PRST, 1, 1, 0, 0, 0));
        // Lock bounce in STABLE after 5 counted cycles; needs a fresh 8.
        vecs.push_back(mk(0, 1,  4, S_WAIT, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1,  1, S_STAB, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1,  3, S_STAB, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0,  2, S_STAB, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1,  1, S_WAIT, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1,  1, S_WAIT, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1,  1, S_STAB, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1,  7, S_STAB, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1,  1, S_RUN,  0, 0, 1, 0, 0));
        // Lock never asserts: three timeouts end in sticky FAIL.
        vecs.push_back(mk(1, 0,  1, S_PRST, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0,  4, S_WAIT, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 31, S_WAIT, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0,  1, S_PRST, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0,  4, S_WAIT, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32, S_PRST, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0,  4, S_WAIT, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 31, S_WAIT, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0,  1, S_FAIL, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 50, S_FAIL, 1, 1, 0, 1, 0));
        // Two timeouts, lock, RUN; after a loss two more timeouts stay out of FAIL, a third does not.
        vecs.push_back(mk(1, 0,  1, S_PRST, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 36, S_PRST, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 36, S_PRST, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1,  4, S_WAIT, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1,  1, S_STAB, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1,  8, S_RUN,  0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0,  3, S_PRST, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0,  4, S_WAIT, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 32, S_PRST, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 36, S_PRST, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 36, S_FAIL, 1, 1, 0, 1, 1));
        // Fresh bring-up ahead of the saturation run.
        vecs.push_back(mk(1, 1,  1, S_PRST, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1,  4, S_WAIT, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1,  1, S_STAB, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1,  8, S_RUN,  0, 0, 1, 0, 0));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // 260 lock losses from RUN; relock_count must stop at 255.
        for (int i = 0; i < 260; i++) begin
            rc = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            apply(mk(0, 0, 3, S_PRST, 1, 1, 0, 0, rc), 1000 + i);
            apply(mk(0, 1, 4, S_WAIT, 0, 1, 0, 0, rc), 1000 + i);
            apply(mk(0, 1, 1, S_STAB, 0, 1, 0, 0, rc), 1000 + i);
            apply(mk(0, 1, 8, S_RUN,  0, 0, 1, 0, rc), 1000 + i);
        end
        apply(mk(1, 1, 1, S_PRST, 1, 1, 0, 0, 0), 2000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
